// File: rtl/attn_inst_seq.sv
// attn_inst_seq: instruction sequencer for the fullchip attention core.
// One start pulse runs K load, Q execute, ofifo->pmem move, sfp acc/div
// with writeback and pmem readout, with programmable idle gaps between phases.
// Optional feature: define SEQ_KREUSE_EN to add the k_reuse input, which skips
// the K load phase and its gap when sampled high together with start.
// GAP_* parameters are expected to be at least 1.
module attn_inst_seq #(
  parameter int unsigned NQ     = 8,
  parameter int unsigned NK     = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned GAP_K  = 11,
  parameter int unsigned GAP_E  = 11,
  parameter int unsigned GAP_O  = 6,
  parameter int unsigned GAP_S  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
`ifdef SEQ_KREUSE_EN
  input  logic                  k_reuse,
`endif
  input  logic                  stall,
  output logic [10+2*ADDR_W:0]  inst,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            phase,
  output logic                  rd_valid
);

  localparam int unsigned IW     = 11 + 2 * ADDR_W;
  localparam int unsigned CW     = 8;
  localparam int unsigned B_DIV  = IW - 1;
  localparam int unsigned B_ACC  = IW - 2;
  localparam int unsigned B_OFR  = IW - 3;
  localparam int unsigned QK_LSB = 8 + ADDR_W;
  localparam int unsigned PM_LSB = 8;
  localparam int unsigned B_EXE  = 7;
  localparam int unsigned B_LOAD = 6;
  localparam int unsigned B_QRD  = 5;
  localparam int unsigned B_KRD  = 3;
  localparam int unsigned B_PRD  = 1;
  localparam int unsigned B_PWR  = 0;

  typedef enum logic [3:0] {
    StIdle, StKload, StKtail, StGapK, StExec, StGapE, StOfifo,
    StGapO, StSfp, StGapS, StRead, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      sub_q, sub_d;
  logic [IW-1:0]   inst_q, inst_d;
  logic [2:0]      phase_q, phase_d;
  logic            busy_q, busy_d, done_q, done_d, rd_valid_q;
  logic            kr;

  function automatic logic at_end(logic [CW-1:0] c, int unsigned n);
    return c == CW'(n - 1);
  endfunction

  // Next-state: counters advance to their terminal value, then the FSM moves on.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    kr      = 1'b0;
`ifdef SEQ_KREUSE_EN
    kr      = k_reuse;
`endif
    unique case (state_q)
      StIdle: if (start) begin
        state_d = kr ? StExec : StKload;
        cnt_d   = '0;
        sub_d   = '0;
      end
      StKload: if (cnt_q == CW'(NK)) begin
        state_d = StKtail;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CW'(1);
      StKtail: state_d = StGapK;
      StGapK: if (!stall) begin
        if (at_end(cnt_q, GAP_K)) begin state_d = StExec; cnt_d = '0; end
        else cnt_d = cnt_q + CW'(1);
      end
      StExec: if (at_end(cnt_q, NQ)) begin state_d = StGapE; cnt_d = '0; end
              else cnt_d = cnt_q + CW'(1);
      StGapE: if (!stall) begin
        if (at_end(cnt_q, GAP_E)) begin state_d = StOfifo; cnt_d = '0; end
        else cnt_d = cnt_q + CW'(1);
      end
      StOfifo: if (at_end(cnt_q, NQ)) begin state_d = StGapO; cnt_d = '0; end
               else cnt_d = cnt_q + CW'(1);
      StGapO: if (!stall) begin
        if (at_end(cnt_q, GAP_O)) begin state_d = StSfp; cnt_d = '0; sub_d = '0; end
        else cnt_d = cnt_q + CW'(1);
      end
      StSfp: if (sub_q == 3'd4) begin
        sub_d = '0;
        if (at_end(cnt_q, NQ)) begin state_d = StGapS; cnt_d = '0; end
        else cnt_d = cnt_q + CW'(1);
      end else sub_d = sub_q + 3'd1;
      StGapS: if (!stall) begin
        if (at_end(cnt_q, GAP_S)) begin state_d = StRead; cnt_d = '0; end
        else cnt_d = cnt_q + CW'(1);
      end
      StRead: if (at_end(cnt_q, NQ)) begin state_d = StDone; cnt_d = '0; end
              else cnt_d = cnt_q + CW'(1);
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode of the next state so every output comes straight from a flop.
  always_comb begin
    inst_d  = '0;
    phase_d = 3'd0;
    unique case (state_d)
      StKload: begin
        phase_d        = 3'd1;
        inst_d[B_LOAD] = 1'b1;
        inst_d[B_KRD]  = (cnt_d != '0);
        if (cnt_d >= CW'(2)) inst_d[QK_LSB +: ADDR_W] = ADDR_W'(cnt_d - CW'(1));
      end
      StKtail: begin
        phase_d        = 3'd1;
        inst_d[B_LOAD] = 1'b1;
      end
      StExec: begin
        phase_d                   = 3'd2;
        inst_d[B_EXE]             = 1'b1;
        inst_d[B_QRD]             = 1'b1;
        inst_d[QK_LSB +: ADDR_W]  = ADDR_W'(cnt_d);
      end
      StOfifo: begin
        phase_d                   = 3'd3;
        inst_d[B_OFR]             = 1'b1;
        inst_d[B_PWR]             = 1'b1;
        inst_d[PM_LSB +: ADDR_W]  = ADDR_W'(cnt_d);
      end
      StSfp: begin
        phase_d                   = 3'd4;
        inst_d[PM_LSB +: ADDR_W]  = ADDR_W'(cnt_d);
        unique case (sub_d)
          3'd0:    inst_d[B_PRD] = 1'b1;
          3'd1:    inst_d[B_ACC] = 1'b1;
          3'd3:    inst_d[B_DIV] = 1'b1;
          3'd4: begin
            inst_d[B_DIV] = 1'b1;
            inst_d[B_PWR] = 1'b1;
          end
          default: ;
        endcase
      end
      StRead: begin
        phase_d                   = 3'd5;
        inst_d[B_PRD]             = 1'b1;
        inst_d[PM_LSB +: ADDR_W]  = ADDR_W'(cnt_d);
      end
      StGapK, StGapE, StGapO, StGapS: phase_d = 3'd6;
      StDone: phase_d = 3'd7;
      default: ;
    endcase
    busy_d = (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);
  end

  // State and registered outputs; reset aborts a pass with no drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sub_q      <= '0;
      inst_q     <= '0;
      phase_q    <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sub_q      <= sub_d;
      inst_q     <= inst_d;
      phase_q    <= phase_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      // fullchip out holds pmem data the cycle after a READ-phase pmem_rd
      rd_valid_q <= (phase_q == 3'd5) && inst_q[B_PRD];
    end
  end

  assign inst     = inst_q;
  assign phase    = phase_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_attn_inst_seq.sv
// Bench for attn_inst_seq: trace-level reference model plus directed literal checks.
module tb_attn_inst_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        k_reuse = 1'b0;
  logic [18:0] inst;
  logic        busy, done, rd_valid;
  logic [2:0]  phase;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  attn_inst_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef SEQ_KREUSE_EN
    .k_reuse  (k_reuse),
`endif
    .stall    (stall),
    .inst     (inst),
    .busy     (busy),
    .done     (done),
    .phase    (phase),
    .rd_valid (rd_valid)
  );

  localparam int NQ = 8, NK = 8, GK = 11, GE = 11, GO = 6, GS = 1;

  typedef struct packed {
    logic [18:0] inst;
    logic [2:0]  phase;
  } step_t;

  step_t       mq[$];
  step_t       st;
  logic [18:0] m_inst  = '0;
  logic [2:0]  m_phase = '0;
  logic        m_rdv   = 1'b0;

  function automatic logic [18:0] f_b(int b);
    return 19'd1 << b;
  endfunction
  function automatic logic [18:0] f_qk(int a);
    return 19'(a) << 12;
  endfunction
  function automatic logic [18:0] f_pm(int a);
    return 19'(a) << 8;
  endfunction

  function automatic void push(logic [18:0] i, logic [2:0] p);
    step_t s;
    s.inst  = i;
    s.phase = p;
    mq.push_back(s);
  endfunction

  // Whole pass as an ordered list of cycles; gaps are phase 6 with inst 0.
  function automatic void build_pass(logic kr);
    if (!kr) begin
      for (int c = 0; c <= NK; c++)
        push(f_b(6) | (c >= 1 ? f_b(3) : 19'd0) | f_qk(c >= 2 ? c - 1 : 0), 3'd1);
      push(f_b(6), 3'd1);
      for (int g = 0; g < GK; g++) push(19'd0, 3'd6);
    end
    for (int c = 0; c < NQ; c++) push(f_b(7) | f_b(5) | f_qk(c), 3'd2);
    for (int g = 0; g < GE; g++) push(19'd0, 3'd6);
    for (int c = 0; c < NQ; c++) push(f_b(16) | f_b(0) | f_pm(c), 3'd3);
    for (int g = 0; g < GO; g++) push(19'd0, 3'd6);
    for (int v = 0; v < NQ; v++) begin
      push(f_b(1) | f_pm(v), 3'd4);
      push(f_b(17) | f_pm(v), 3'd4);
      push(f_pm(v), 3'd4);
      push(f_b(18) | f_pm(v), 3'd4);
      push(f_b(18) | f_b(0) | f_pm(v), 3'd4);
    end
    for (int g = 0; g < GS; g++) push(19'd0, 3'd6);
    for (int c = 0; c < NQ; c++) push(f_b(1) | f_pm(c), 3'd5);
    push(19'd0, 3'd7);
  endfunction

  // Reference model: replays the pass, repeating a gap cycle whenever stall is high.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_inst  = '0;
      m_phase = '0;
      m_rdv   = 1'b0;
    end else begin
      m_rdv = (m_phase == 3'd5) && m_inst[1];
      if (m_phase == 3'd6 && stall) begin
      end else if (mq.size() > 0) begin
        st = mq.pop_front();
        m_inst = st.inst;
        m_phase = st.phase;
      end else if (m_phase == 3'd0 && start) begin
        build_pass(k_reuse);
        st = mq.pop_front();
        m_inst = st.inst;
        m_phase = st.phase;
      end else begin
        m_inst  = '0;
        m_phase = '0;
      end
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    logic m_busy, m_done;
    m_busy = (m_phase != 3'd0) && (m_phase != 3'd7);
    m_done = (m_phase == 3'd7);
    total++;
    if ({inst, phase, busy, done, rd_valid} !== {m_inst, m_phase, m_busy, m_done, m_rdv}) begin
      bad++;
      $display("FAIL model_cycle t=%0t actual inst=%h ph=%0d busy=%b done=%b rdv=%b required inst=%h ph=%0d busy=%b done=%b rdv=%b",
               $time, inst, phase, busy, done, rd_valid, m_inst, m_phase, m_busy, m_done, m_rdv);
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  logic [18:0] log_inst [0:400];
  logic [2:0]  log_phase[0:400];
  int done_at, busy_cnt, first_ofifo;

  // mode 0: quiet, 1: directed stall schedule, 2: random stall and start noise
  task automatic run_pass(input int mode, input logic kr, input int exp_done);
    @(negedge clk);
    start = 1'b1;
    k_reuse = kr;
    @(negedge clk);
    start = 1'b0;
    k_reuse = 1'b0;
    done_at = 0;
    busy_cnt = 0;
    first_ofifo = 0;
    for (int n = 1; n <= 400; n++) begin
      if (n > 1) @(negedge clk);
      log_inst[n]  = inst;
      log_phase[n] = phase;
      if (busy) busy_cnt++;
      if (phase == 3'd3 && first_ofifo == 0) first_ofifo = n;
      if (done) begin
        done_at = n;
        break;
      end
      if (mode == 1) stall = (n >= 30 && n <= 36) || (n >= 48 && n <= 55);
      else if (mode == 2) begin
        stall = ($urandom_range(0, 2) == 0);
        start = ($urandom_range(0, 15) == 0);
      end
    end
    stall = 1'b0;
    start = 1'b0;
    check("pass_done", done_at != 0, 1);
    if (exp_done != 0) begin
      check("done_cycle", done_at, exp_done);
      check("busy_len", busy_cnt, exp_done - 1);
    end
  endtask

  int exp_qk  [9] = '{0, 0, 1, 2, 3, 4, 5, 6, 7};
  int exp_krd [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
  logic [18:0] exp_sfp [5] = '{19'h00302, 19'h20300, 19'h00300, 19'h40300, 19'h40301};

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_quiet", {inst, busy, phase}, 0);
    end

    // Default pass with literal pins on KLOAD and SFP v=3.
    run_pass(0, 1'b0, 104);
    for (int i = 0; i < 9; i++) begin
      check("kload_qk", log_inst[i+1][15:12], exp_qk[i]);
      check("kload_krd", log_inst[i+1][3], exp_krd[i]);
    end
    for (int i = 0; i < 5; i++) check("sfp_v3", log_inst[70+i], exp_sfp[i]);
    stray = 0;
    for (int n = 1; n <= done_at; n++)
      if (log_phase[n] != 3'd4 && (log_inst[n][18] || log_inst[n][17])) stray++;
    check("no_div_acc_outside_sfp", stray, 0);

    // Stall 7 cycles in GAP_E, and during OFIFO where it must be ignored.
    run_pass(1, 1'b0, 111);
    check("ofifo_start_after_stall", first_ofifo, 48);

    // Restart ignored mid-EXEC, then asynchronous reset mid-OFIFO.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("pre_reset_phase", phase, 3);
    #2 reset = 1'b0;
    #1 check("async_reset_outputs", {inst, phase, busy, done, rd_valid}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_pass(0, 1'b0, 104);

`ifdef SEQ_KREUSE_EN
    run_pass(0, 1'b1, 83);
    check("kreuse_first_inst", log_inst[1], 19'h000A0);
`endif

    for (int r = 0; r < 3; r++) run_pass(2, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/attn_inst_seq.md
Name: attn_inst_seq

Overview:
- Hardware instruction sequencer that drives the 19-bit `inst` bus of the fullchip attention core.
- Replaces hand-stepped bench control with a parametrised FSM.
- Sequence: K load, Q execute, ofifo→pmem move, sfp accumulate/divide with writeback, pmem readout.
- Sits between the host/top-level controller and fullchip; one `start` pulse runs a full attention pass.

Parameters:
NQ, 8, number of streamed Q vectors (total_cycle)
NK, 8, number of K vectors / dot-product columns (col)
ADDR_W, 4, qkmem_add and pmem_add width; NQ and NK must be ≤ 2**ADDR_W
GAP_K, 11, idle cycles after K load tail
GAP_E, 11, idle cycles after execute
GAP_O, 6, idle cycles after ofifo move
GAP_S, 1, idle cycles after sfp phase

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to run one pass; ignored while busy
stall  input  1  holds the FSM in any GAP state while high
inst  output  19  {div,acc,ofifo_rd,qkmem_add[3:0],pmem_add[3:0],execute,load,qmem_rd,qmem_wr,kmem_rd,kmem_wr,pmem_rd,pmem_wr}, bit 18 down to 0 (with ADDR_W=4)
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the last READ cycle
phase  output  3  0 IDLE, 1 KLOAD, 2 EXEC, 3 OFIFO, 4 SFP, 5 READ, 6 GAP, 7 DONE
rd_valid  output  1  high the cycle after each READ-phase pmem_rd, i.e. when fullchip `out` holds pmem data

Behaviour:
- All outputs are registered. While reset is low: inst=0, busy=0, done=0, phase=0, rd_valid=0, FSM in IDLE, all counters 0. Reset mid-pass aborts immediately with no drain.
- IDLE: inst=0. start=1 at edge E0 → KLOAD. The first KLOAD inst is visible in the cycle after E0. `busy` rises at the same time.
- KLOAD, counter c=0..NK (NK+1 cycles): load=1; kmem_rd=(c≥1); qkmem_add = (c≥2) ? c-1 : 0.
- KTAIL, 1 cycle: load=1; all other bits 0.
- GAP states: inst=0 for the programmed count. If stall=1, the FSM remains in the GAP state and the count freezes. stall is ignored in every other state.
- EXEC, c=0..NQ-1: execute=1, qmem_rd=1, qkmem_add=c. Followed by GAP_E.
- OFIFO, c=0..NQ-1: ofifo_rd=1, pmem_wr=1, pmem_add=c. Followed by GAP_O.
- SFP: for each vector v=0..NQ-1, 5 substeps, with pmem_add=v held across all 5:
  - S0: pmem_rd=1
  - S1: acc=1
  - S2: all control bits 0
  - S3: div=1
  - S4: div=1, pmem_wr=1
  - Followed by GAP_S.
- READ, c=0..NQ-1: pmem_rd=1, pmem_add=c. rd_valid is this cycle's pmem_rd delayed one cycle.
- DONE, 1 cycle: done=1, busy=0, inst=0. Then IDLE. start during DONE is ignored.
- Never asserted by the sequencer: qmem_wr, kmem_wr (memory fill stays with the host).
- Counters saturate at their terminal value and never wrap. Address fields are zero-extended into inst.
- Pass length with defaults: done is high in cycle 104 after E0, derived from (NK+1) + 1 + GAP_K + NQ + GAP_E + NQ + GAP_O + 5·NQ + GAP_S + NQ = 103.

Optional Feature:
- Macro: SEQ_KREUSE_EN.
- With the macro defined: an extra input `k_reuse` (1 bit) is sampled together with start. If k_reuse=1, KLOAD, KTAIL and the GAP_K gap are skipped and EXEC starts in the cycle after E0. With defaults, done is then in cycle 83 after E0.
- Without the macro: the port is absent and every pass loads K.

Test Plan:
- Reset low for 3 cycles, then high, no start → inst=0, busy=0, phase=0 for 20 cycles.
- start pulse (defaults) → KLOAD cycles 0..8 show qkmem_add 0,0,1..7 and kmem_rd 0,1,1..1. done pulses exactly in cycle 104 after E0. busy stays high for 103 cycles.
- During SFP of v=3 → pmem_add=3 for 5 cycles with pattern pmem_rd, acc, none, div, div+pmem_wr. No div/acc bits appear outside SFP.
- stall=1 for 7 cycles starting in GAP_E → EXEC→OFIFO gap lengthens to 18 cycles and done moves to cycle 111. stall held during OFIFO has no effect.
- start re-pulsed mid-EXEC, then reset pulled low in OFIFO → second start ignored. All outputs 0 asynchronously. A subsequent start runs a clean full pass.
- With SEQ_KREUSE_EN, start with k_reuse=1 → first non-zero inst is execute with qkmem_add=0 in the cycle after E0, and done arrives in cycle 83.
